router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx_if.sv | 29 ++
 rtl/router_pkt_tx.sv | 137 +++++++++++++
 tb/tb_router_pkt_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Upstream/router signal bundle for router_pkt_tx.
// master = the side that supplies start/payload/router status; slave = router_pkt_tx.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       err;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       idle;
  logic       done;
  logic       bad_req;
  logic       abort;
  logic       err_flag;

  modport master (
    output start, dest, len, pl_data, pl_valid, busy, err,
    input  pl_ready, data_in, pkt_valid, idle, done, bad_req, abort, err_flag
  );

  modport slave (
    input  start, dest, len, pl_data, pl_valid, busy, err,
    output pl_ready, data_in, pkt_valid, idle, done, bad_req, abort, err_flag
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers a len-byte payload, then sends header/payload/parity to the router; header appears len+1 cycles
// after start when pl_valid stays high, each beat holds while busy, and BUSY_LIMIT straight busy cycles abort.
module router_pkt_tx #(
  parameter int BUSY_LIMIT = 30
) (
  input  logic            clk,
  input  logic            reset,
  router_pkt_tx_if.slave  bus
);
  localparam int SW = $clog2(BUSY_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, ERRWIN} state_t;

  state_t          state;
  logic [1:0]      dest_q;
  logic [5:0]      len_q;
  logic [5:0]      wr_idx;
  logic [5:0]      rd_idx;
  logic [7:0]      par_q;
  logic [SW-1:0]   stall_cnt;
  logic [1:0]      ew_cnt;
  logic [7:0]      pbuf [64];

  // Payload store kept out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.pl_valid) pbuf[wr_idx] <= bus.pl_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      dest_q       <= '0;
      len_q        <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      par_q        <= '0;
      stall_cnt    <= '0;
      ew_cnt       <= '0;
      bus.pl_ready <= 1'b0;
      bus.data_in  <= '0;
      bus.pkt_valid<= 1'b0;
      bus.idle     <= 1'b1;
      bus.done     <= 1'b0;
      bus.bad_req  <= 1'b0;
      bus.abort    <= 1'b0;
      bus.err_flag <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.bad_req <= 1'b0;
      bus.abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.dest != 2'd3 && bus.len != 6'd0) begin
              dest_q       <= bus.dest;
              len_q        <= bus.len;
              wr_idx       <= '0;
              rd_idx       <= '0;
              par_q        <= '0;
              stall_cnt    <= '0;
              bus.err_flag <= 1'b0;
              bus.pl_ready <= 1'b1;
              bus.idle     <= 1'b0;
              state        <= LOAD;
            end else begin
              bus.bad_req <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.pl_valid) begin
            if (wr_idx == len_q - 6'd1) begin
              // Fold the header into the parity now so the parity beat is a straight register copy.
              par_q         <= par_q ^ bus.pl_data ^ {len_q, dest_q};
              bus.pl_ready  <= 1'b0;
              bus.data_in   <= {len_q, dest_q};
              bus.pkt_valid <= 1'b1;
              state         <= HEADER;
            end else begin
              par_q  <= par_q ^ bus.pl_data;
              wr_idx <= wr_idx + 6'd1;
            end
          end
        end
        HEADER, PAYLOAD, PARITY: begin
          if (bus.busy) begin
            if (stall_cnt == SW'(BUSY_LIMIT - 1)) begin
              bus.abort     <= 1'b1;
              bus.pkt_valid <= 1'b0;
              bus.data_in   <= '0;
              bus.idle      <= 1'b1;
              stall_cnt     <= '0;
              state         <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end else begin
            stall_cnt <= '0;
            if (state == HEADER) begin
              bus.data_in <= pbuf[0];
              rd_idx      <= 6'd1;
              state       <= PAYLOAD;
            end else if (state == PAYLOAD) begin
              // rd_idx counts bytes already driven; equal to len means the last one was just taken.
              if (rd_idx == len_q) begin
                bus.data_in   <= par_q;
                bus.pkt_valid <= 1'b0;
                state         <= PARITY;
              end else begin
                bus.data_in <= pbuf[rd_idx];
                rd_idx      <= rd_idx + 6'd1;
              end
            end else begin
              bus.data_in <= '0;
              ew_cnt      <= '0;
              state       <= ERRWIN;
            end
          end
        end
        ERRWIN: begin
          bus.err_flag <= bus.err_flag | bus.err;
          if (ew_cnt == 2'd2) begin
            bus.done <= 1'b1;
            bus.idle <= 1'b1;
            state    <= IDLE;
          end else begin
            ew_cnt <= ew_cnt + 2'd1;
          end
        end
        default: begin
          bus.idle <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed packets plus randomized traffic checked against an expected beat list.
module tb_router_pkt_tx;
  localparam int BUSY_LIMIT = 30;

  logic clk = 1'b0;
  logic reset;
  router_pkt_tx_if bus();

  router_pkt_tx #(.BUSY_LIMIT(BUSY_LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] pay [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [14:0] outs();
    return {bus.data_in, bus.pkt_valid, bus.pl_ready, bus.done, bus.bad_req,
            bus.abort, bus.err_flag, bus.idle};
  endfunction

  task automatic bad_start(input logic [1:0] d, input logic [5:0] l);
    bus.start = 1'b1; bus.dest = d; bus.len = l;
    @(negedge clk);
    bus.start = 1'b0;
    chk("bad_req", {bus.bad_req, bus.idle, bus.pl_ready, bus.pkt_valid}, 4'b1100);
    @(negedge clk);
    chk("bad_req_1cyc", {bus.bad_req, bus.idle, bus.pl_ready, bus.pkt_valid}, 4'b0100);
  endtask

  // Entered and left at a negedge with the DUT idle (or just reset).
  task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input int gap_pct,
                         input int busy_pct, input int stall_beat, input int stall_len,
                         input int rst_beat, input logic [2:0] err_pat);
    logic [7:0] exp_b [$];
    logic [7:0] par;
    int k, bi, run, st_left, guard;
    bit b;
    logic ef;
    par = {l, d};
    exp_b.push_back(par);
    for (int i = 0; i < int'(l); i++) begin
      exp_b.push_back(pay[i]);
      par ^= pay[i];
    end
    exp_b.push_back(par);

    bus.start = 1'b1; bus.dest = d; bus.len = l;
    @(negedge clk);
    chk("start_load", {bus.idle, bus.pl_ready, bus.pkt_valid}, 3'b010);
    chk("err_flag_clr", bus.err_flag, 1'b0);

    k = 0; guard = 0;
    while (k < int'(l) && guard < 1000) begin
      chk("load_ready", {bus.pl_ready, bus.pkt_valid, bus.idle}, 3'b100);
      // Valid-looking starts while busy must be ignored.
      bus.start    = 1'($urandom);
      bus.dest     = 2'd0;
      bus.len      = 6'd1;
      bus.pl_valid = ($urandom_range(99) >= gap_pct);
      bus.pl_data  = bus.pl_valid ? pay[k] : 8'($urandom);
      bus.err      = 1'($urandom);
      bus.busy     = 1'($urandom);
      @(negedge clk);
      if (bus.pl_valid) k++;
      guard++;
    end
    bus.pl_valid = 1'b0; bus.start = 1'b0;
    if (guard >= 1000) chk("load_timeout", 32'd0, 32'd1);
    chk("load_done_rdy", bus.pl_ready, 1'b0);

    bi = 0; run = 0; st_left = stall_len;
    while (bi < int'(l) + 2) begin
      if (bi == rst_beat) begin
        reset = 1'b0; bus.busy = 1'b0;
        @(negedge clk);
        chk("reset_mid_pkt", outs(), {8'h00, 6'b000000, 1'b1});
        reset = 1'b1;
        return;
      end
      chk("beat_data", bus.data_in, exp_b[bi]);
      chk("beat_pv", bus.pkt_valid, bi <= int'(l));
      chk("beat_no_pulse", {bus.abort, bus.done, bus.idle, bus.pl_ready}, 4'b0000);
      if (bi == stall_beat && st_left > 0) begin
        b = 1'b1;
        st_left--;
      end else begin
        b = (run < 6) && ($urandom_range(99) < busy_pct);
      end
      bus.busy = b;
      bus.err  = 1'($urandom);
      @(negedge clk);
      if (b) begin
        run++;
        if (run == BUSY_LIMIT) begin
          chk("abort", {bus.abort, bus.pkt_valid, bus.idle, bus.done}, 4'b1010);
          bus.busy = 1'b0;
          @(negedge clk);
          chk("abort_1cyc", {bus.abort, bus.done, bus.idle}, 3'b001);
          return;
        end
      end else begin
        run = 0;
        bi++;
      end
    end

    ef = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("errwin_wait", {bus.done, bus.idle, bus.pkt_valid}, 3'b000);
      bus.err  = err_pat[j];
      ef       = ef | err_pat[j];
      bus.busy = 1'($urandom);
      @(negedge clk);
    end
    bus.err = 1'b1;
    chk("done", {bus.done, bus.idle, bus.pkt_valid}, 3'b110);
    chk("err_flag", bus.err_flag, ef);
    @(negedge clk);
    bus.err = 1'b0;
    chk("done_1cyc", bus.done, 1'b0);
    chk("err_flag_sticky", bus.err_flag, ef);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] d;
    logic [5:0] l;
    reset = 1'b0;
    bus.start = 1'b0; bus.dest = '0; bus.len = '0; bus.pl_data = '0;
    bus.pl_valid = 1'b0; bus.busy = 1'b0; bus.err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", outs(), {8'h00, 6'b000000, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", outs(), {8'h00, 6'b000000, 1'b1});

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    run_pkt(2'd1, 6'd4, 0, 0, -1, 0, -1, 3'b000);
    run_pkt(2'd1, 6'd4, 0, 0, 2, 2, -1, 3'b000);
    bad_start(2'd3, 6'd5);
    bad_start(2'd2, 6'd0);
    run_pkt(2'd1, 6'd4, 0, 0, 0, BUSY_LIMIT, -1, 3'b000);
    run_pkt(2'd1, 6'd4, 0, 0, -1, 0, -1, 3'b010);
    run_pkt(2'd0, 6'd1, 0, 0, -1, 0, -1, 3'b100);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_idle_clears", outs(), {8'h00, 6'b000000, 1'b1});
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    run_pkt(2'd2, 6'd63, 0, 0, -1, 0, 10, 3'b000);
    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    run_pkt(2'd2, 6'd63, 0, 0, -1, 0, -1, 3'b001);

    for (int p = 0; p < 24; p++) begin
      d = 2'($urandom_range(0, 2));
      l = (p % 4 == 0) ? 6'd63 : 6'($urandom_range(1, 63));
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      if (p % 7 == 3) bad_start(2'd3, 6'($urandom));
      run_pkt(d, l, 25, 30, -1, 0, -1, 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
